fifo_rd_stream: RTL and testbench

- Read-side consumer for the asynchronous FIFO. It drains the FIFO read port (`empty` / `r_en` / `rdata`) in the read clock domain.
- It presents the words as a valid/ready output stream with a 2-entry skid buffer. This absorbs the FIFO's 1-cycle read latency and sustains 1 word/cycle.
- It also provides a synchronous flush and a delivered-word counter.

---
 rtl/fifo_rd_stream_if.sv | 27 ++
 rtl/fifo_rd_stream.sv | 116 +++++++++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle between the async FIFO read port, the output stream and
// the local control/status lines of fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int DATA = 8,
  parameter int CNTW = 16
);
  logic            empty;
  logic [DATA-1:0] rdata;
  logic            r_en;
  logic            m_valid;
  logic [DATA-1:0] m_data;
  logic            m_ready;
  logic            flush;
  logic [CNTW-1:0] rd_count;

  // master: the stream block itself (drains FIFO, sources the stream)
  modport master (
    input  empty, rdata, m_ready, flush,
    output r_en, m_valid, m_data, rd_count
  );

  // slave: FIFO read port plus downstream consumer
  modport slave (
    output empty, rdata, m_ready, flush,
    input  r_en, m_valid, m_data, rd_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port in the read clock domain and presents the
// words as a registered valid/ready stream through a 2-entry skid buffer.
// The skid buffer hides the FIFO's 1-cycle read latency, so a word can be
// requested every cycle while the consumer keeps up.
//
//   state (occ) | meaning
//   ------------+-------------------------------------------------
//   OCC_EMPTY   | nothing buffered, m_valid=0
//   OCC_ONE     | entry0 holds the head word, m_valid=1
//   OCC_TWO     | entry0 head, entry1 next word, m_valid=1
module fifo_rd_stream #(
  parameter int DATA = 8,
  parameter int CNTW = 16
) (
  input logic              rclk,
  input logic              rrst,
  fifo_rd_stream_if.master bus
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]      occ;
  logic [1:0]      occ_nxt;
  logic            inflight;
  logic [DATA-1:0] entry0;
  logic [DATA-1:0] entry1;
  logic [DATA-1:0] entry0_nxt;
  logic [DATA-1:0] entry1_nxt;
  logic            valid_q;
  logic [CNTW-1:0] count;

  logic            pop;
  logic            push;
  logic [1:0]      claimed;
  logic            room;
  logic            issue;

  assign pop  = valid_q && bus.m_ready;
  assign push = inflight && ~bus.flush;

  // Slots already spoken for: buffered words plus the one still in flight.
  // occ + inflight never exceeds 2, and pop implies occ >= 1, so no wrap.
  assign claimed = occ + {1'b0, inflight};
  assign room    = (claimed - {1'b0, pop}) < 2'd2;

  // The m_ready -> r_en path is deliberate: freeing a slot this cycle lets a
  // new read go out in the same cycle, which is what sustains 1 word/cycle.
  assign issue = rrst && ~bus.empty && ~bus.flush && room;

  assign bus.r_en     = issue;
  assign bus.m_valid  = valid_q;
  assign bus.m_data   = entry0;
  assign bus.rd_count = count;

  // Skid-buffer next state; flush wins over an arriving word.
  always_comb begin
    occ_nxt    = occ;
    entry0_nxt = entry0;
    entry1_nxt = entry1;
    if (bus.flush) begin
      occ_nxt = OCC_EMPTY;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == OCC_EMPTY) begin
            entry0_nxt = bus.rdata;
            occ_nxt    = OCC_ONE;
          end else begin
            entry1_nxt = bus.rdata;
            occ_nxt    = OCC_TWO;
          end
        end
        2'b01: begin
          entry0_nxt = entry1;
          occ_nxt    = occ - 2'd1;
        end
        2'b11: begin
          if (occ == OCC_ONE) begin
            entry0_nxt = bus.rdata;
          end else begin
            entry0_nxt = entry1;
            entry1_nxt = bus.rdata;
          end
        end
        default: begin
          occ_nxt = occ;
        end
      endcase
    end
  end

  // State registers; m_valid is kept as its own flop so the stream outputs
  // come straight from registers.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      entry0   <= '0;
      entry1   <= '0;
      valid_q  <= 1'b0;
      count    <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= issue;
      entry0   <= entry0_nxt;
      entry1   <= entry1_nxt;
      valid_q  <= (occ_nxt != OCC_EMPTY);
      if (pop) begin
        count <= count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO emulation feeds the read port,
// every accepted read pushes its word into a scoreboard, and a negedge
// monitor compares the stream, r_en and rd_count against that scoreboard.
module tb_fifo_rd_stream;
  localparam int DATA = 8;
  localparam int CNTW = 4;

  typedef struct {
    logic [DATA-1:0] data;
    int              avail;
  } ent_t;

  logic rclk = 1'b0;
  logic rrst = 1'b0;

  fifo_rd_stream_if #(.DATA(DATA), .CNTW(CNTW)) bus ();
  fifo_rd_stream #(.DATA(DATA), .CNTW(CNTW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  int              acc_count = 0;
  logic [DATA-1:0] fifo_q[$];
  ent_t            exp_q[$];
  logic [CNTW-1:0] cnt_model = '0;
  logic            have_word = 1'b0;
  logic [DATA-1:0] word_out  = '0;
  int              ready_mode = 0;
  int              gate_mode  = 0;
  int              flush_pct  = 0;
  logic            force_flush = 1'b0;
  logic            tog = 1'b0;

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One read-clock cycle: inputs at +1 after the edge, read acceptance at +3.
  task automatic step();
    logic gate;
    @(posedge rclk);
    #1;
    bus.rdata = have_word ? word_out : DATA'($urandom);
    have_word = 1'b0;
    case (gate_mode)
      1:       gate = tog;
      2:       gate = ($urandom_range(0, 2) == 0);
      default: gate = 1'b0;
    endcase
    tog = ~tog;
    bus.empty = (fifo_q.size() == 0) || gate;
    case (ready_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'b0;
      default: bus.m_ready = ($urandom_range(0, 3) != 0);
    endcase
    bus.flush = force_flush || ($urandom_range(0, 99) < flush_pct);
    #2;
    if (bus.r_en && !bus.empty) begin
      word_out  = fifo_q.pop_front();
      have_word = 1'b1;
      exp_q.push_back('{data: word_out, avail: cyc + 2});
      acc_count++;
    end
  endtask

  task automatic load(input int n, input logic [DATA-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DATA'(i));
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || have_word) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(n), 32'd0);
    repeat (2) step();
  endtask

  // Scoreboard monitor: predicts m_valid/m_data/r_en/rd_count from the
  // accepted-word queue and retires words on each handshake.
  always @(negedge rclk) begin
    int   n_old;
    logic exp_valid;
    logic exp_pop;
    logic exp_ren;
    if (!rrst) begin
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_r_en", 32'(bus.r_en), 32'd0);
      check("rst_rd_count", 32'(bus.rd_count), 32'd0);
      exp_q.delete();
      cnt_model = '0;
    end else begin
      n_old = 0;
      foreach (exp_q[i]) if (exp_q[i].avail <= cyc + 1) n_old++;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("outstanding_le_2", 32'(n_old <= 2), 32'd1);
      check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
      if (exp_valid) check("m_data", 32'(bus.m_data), 32'(exp_q[0].data));
      check("rd_count", 32'(bus.rd_count), 32'(cnt_model));
      exp_pop = exp_valid && bus.m_ready;
      exp_ren = !bus.empty && !bus.flush && ((n_old - int'(exp_pop)) < 2);
      check("r_en", 32'(bus.r_en), 32'(exp_ren));
      if (exp_pop) begin
        void'(exp_q.pop_front());
        cnt_model = cnt_model + CNTW'(1);
      end
      if (bus.flush) exp_q.delete();
    end
  end

  initial begin
    int a0;
    bus.empty = 1'b1;
    bus.rdata = '0;
    bus.m_ready = 1'b0;
    bus.flush = 1'b0;
    #2;
    check("init_m_valid", 32'(bus.m_valid), 32'd0);
    check("init_r_en", 32'(bus.r_en), 32'd0);
    check("init_m_data", 32'(bus.m_data), 32'd0);
    check("init_rd_count", 32'(bus.rd_count), 32'd0);
    @(posedge rclk);
    #1 rrst = 1'b1;
    repeat (2) step();

    // three words, consumer always ready
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    ready_mode = 0;
    drain();
    check("t1_rd_count", 32'(bus.rd_count), 32'd3);

    // back-pressure: only two reads may go out
    load(4, 8'hA1);
    ready_mode = 1;
    a0 = acc_count;
    repeat (6) step();
    check("bp_reads", 32'(acc_count - a0), 32'd2);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check("bp_m_data", 32'(bus.m_data), 32'hA1);
    check("bp_r_en", 32'(bus.r_en), 32'd0);
    ready_mode = 0;
    drain();
    check("bp_rd_count", 32'(bus.rd_count), 32'd7);

    // empty toggling every cycle
    load(8, 8'h40);
    gate_mode = 1;
    a0 = acc_count;
    drain();
    gate_mode = 0;
    check("tog_reads", 32'(acc_count - a0), 32'd8);
    check("tog_rd_count", 32'(bus.rd_count), 32'd15);

    // flush with a full buffer, held for three cycles
    load(6, 8'hB1);
    ready_mode = 1;
    repeat (4) step();
    force_flush = 1'b1;
    repeat (3) step();
    force_flush = 1'b0;
    check("fl_rd_count", 32'(bus.rd_count), 32'd15);
    check("fl_m_valid", 32'(bus.m_valid), 32'd0);
    ready_mode = 0;
    drain();
    check("fl_after_count", 32'(bus.rd_count), 32'd3);

    // asynchronous reset in the middle of a stream
    load(10, 8'hC0);
    ready_mode = 1;
    repeat (4) step();
    check("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    @(posedge rclk);
    #2 rrst = 1'b0;
    #1;
    check("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check("arst_r_en", 32'(bus.r_en), 32'd0);
    check("arst_m_data", 32'(bus.m_data), 32'd0);
    check("arst_rd_count", 32'(bus.rd_count), 32'd0);
    fifo_q.delete();
    have_word = 1'b0;
    bus.empty = 1'b1;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge rclk);
    #1 rrst = 1'b1;

    // 17 fresh words wrap the 4-bit counter to 1
    load(17, 8'hD0);
    ready_mode = 0;
    drain();
    check("wrap_rd_count", 32'(bus.rd_count), 32'd1);

    // randomized traffic with random stalls, gaps and flushes
    ready_mode = 2;
    gate_mode = 2;
    flush_pct = 6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) fifo_q.push_back(DATA'($urandom));
      step();
    end
    flush_pct = 0;
    gate_mode = 0;
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
